// File: rtl/prf_pkg.sv
// Shared types and defaults for the parametrised short/long register file.
package prf_pkg;

   typedef enum logic {PRF_CLEAR = 1'b0, PRF_IDLE = 1'b1} prf_state_e;

   localparam int DEF_SHORT_W  = 16;
   localparam int DEF_LONG_W   = 24;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_LONG = 4;

   // The long registers occupy the topmost num_long indices.
   function automatic bit is_long(input int idx, input int num_regs, input int num_long);
      return idx >= (num_regs - num_long);
   endfunction

endpackage

// File: rtl/prf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, reserve sets, release clears.
module prf_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             rsv_en,
   input  logic [IDX_W-1:0] rsv_idx,
   input  logic             rel_en,
   input  logic [IDX_W-1:0] rel_idx,
   input  logic [IDX_W-1:0] rd_idx_1,
   input  logic [IDX_W-1:0] rd_idx_2,
   output logic             pend_1,
   output logic             pend_2
);

   logic [NUM_REGS-1:0] pending;

   // Reserve is applied after release so a same-index collision leaves the bit set.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         pending <= '0;
      end else begin
         if (rel_en) pending[rel_idx] <= 1'b0;
         if (rsv_en) pending[rsv_idx] <= 1'b1;
      end
   end

   assign pend_1 = pending[rd_idx_1];
   assign pend_2 = pending[rd_idx_2];

endmodule

// File: rtl/param_register_file.sv
// Parametrised short/long register file with bulk clear, pending scoreboard and ready flag.
// Define PRF_BYPASS_EN to forward same-cycle writes to the read ports.
module param_register_file import prf_pkg::*; #(
   parameter int SHORT_W  = DEF_SHORT_W,
   parameter int LONG_W   = DEF_LONG_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_LONG = DEF_NUM_LONG,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_idx_1,
   input  logic [IDX_W-1:0]  rd_idx_2,
   output logic [LONG_W-1:0] rd_data_1,
   output logic [LONG_W-1:0] rd_data_2,
   output logic              busy_1,
   output logic              busy_2,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [LONG_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [IDX_W-1:0]  rsv_idx,
   input  logic              clr_req,
   output logic              ready
);

   localparam logic [LONG_W-1:0] SHORT_MASK = {LONG_W{1'b1}} >> (LONG_W - SHORT_W);

   prf_state_e        state;
   logic [IDX_W-1:0]  clr_ptr;
   logic [LONG_W-1:0] regs [NUM_REGS];
   logic              wr_go;
   logic              rsv_go;
   logic              sb_clr;
   logic              pend_1;
   logic              pend_2;

   // Short destinations keep only their low SHORT_W bits, so reads need no masking.
   function automatic logic [LONG_W-1:0] fit(input logic [LONG_W-1:0] d,
                                             input logic [IDX_W-1:0]  idx);
      if (is_long(int'(idx), NUM_REGS, NUM_LONG)) return d;
      return d & SHORT_MASK;
   endfunction

   assign wr_go  = wr_en && ready;
   assign rsv_go = rsv_en && ready;
   assign sb_clr = (state == PRF_CLEAR) || (state == PRF_IDLE && clr_req);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= PRF_CLEAR;
         clr_ptr <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            PRF_CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == IDX_W'(NUM_REGS - 1)) begin
                  state <= PRF_IDLE;
                  ready <= 1'b1;
               end
            end
            default: begin
               if (clr_req) begin
                  state   <= PRF_CLEAR;
                  clr_ptr <= '0;
                  ready   <= 1'b0;
               end
            end
         endcase
      end
   end

   // Storage carries no reset; the clear sequence zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (state == PRF_CLEAR) regs[clr_ptr] <= '0;
      else if (wr_go)         regs[wr_idx]  <= fit(wr_data, wr_idx);
   end

   prf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sb_clr),
      .rsv_en   (rsv_go),
      .rsv_idx  (rsv_idx),
      .rel_en   (wr_go),
      .rel_idx  (wr_idx),
      .rd_idx_1 (rd_idx_1),
      .rd_idx_2 (rd_idx_2),
      .pend_1   (pend_1),
      .pend_2   (pend_2)
   );

   always_comb begin
      rd_data_1 = '0;
      rd_data_2 = '0;
      busy_1    = 1'b0;
      busy_2    = 1'b0;
      if (ready) begin
         rd_data_1 = regs[rd_idx_1];
         rd_data_2 = regs[rd_idx_2];
         busy_1    = pend_1;
         busy_2    = pend_2;
`ifdef PRF_BYPASS_EN
         if (wr_en && wr_idx == rd_idx_1) begin
            rd_data_1 = fit(wr_data, wr_idx);
            busy_1    = 1'b0;
         end
         if (wr_en && wr_idx == rd_idx_2) begin
            rd_data_2 = fit(wr_data, wr_idx);
            busy_2    = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: default 32x(16/24) instance plus an 8-entry all-short instance.
module tb_param_register_file;

   localparam int S_RDY  = 0;
   localparam int S_RD1  = 1;
   localparam int S_RD2  = 2;
   localparam int S_BSY1 = 3;
   localparam int S_BSY2 = 4;
   localparam int S_RDY8 = 5;
   localparam int S_RD81 = 6;
   localparam int S_RD82 = 7;
   localparam int S_B81  = 8;
   localparam int S_B82  = 9;

   typedef struct {
      string       name;
      int          sel;
      logic [23:0] exp;
   } sb_entry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rd_idx_1, rd_idx_2, wr_idx, rsv_idx;
   logic        wr_en, rsv_en, clr_req;
   logic [23:0] wr_data;
   logic [23:0] rd_data_1, rd_data_2, rd8_1, rd8_2;
   logic        busy_1, busy_2, busy8_1, busy8_2, ready, ready8;

   sb_entry_t sbq[$];
   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   param_register_file dut (
      .clk(clk), .rst_n(rst_n),
      .rd_idx_1(rd_idx_1), .rd_idx_2(rd_idx_2),
      .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
      .busy_1(busy_1), .busy_2(busy_2),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_idx(rsv_idx),
      .clr_req(clr_req), .ready(ready)
   );

   param_register_file #(.NUM_REGS(8), .NUM_LONG(0)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .rd_idx_1(rd_idx_1[2:0]), .rd_idx_2(rd_idx_2[2:0]),
      .rd_data_1(rd8_1), .rd_data_2(rd8_2),
      .busy_1(busy8_1), .busy_2(busy8_2),
      .wr_en(wr_en), .wr_idx(wr_idx[2:0]), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_idx(rsv_idx[2:0]),
      .clr_req(clr_req), .ready(ready8)
   );

   function automatic logic [23:0] observe(input int sel);
      case (sel)
         S_RDY:   return {23'd0, ready};
         S_RD1:   return rd_data_1;
         S_RD2:   return rd_data_2;
         S_BSY1:  return {23'd0, busy_1};
         S_BSY2:  return {23'd0, busy_2};
         S_RDY8:  return {23'd0, ready8};
         S_RD81:  return rd8_1;
         S_RD82:  return rd8_2;
         S_B81:   return {23'd0, busy8_1};
         S_B82:   return {23'd0, busy8_2};
         default: return 24'hxxxxxx;
      endcase
   endfunction

   // Monitor: the outputs are combinational, so every queued expectation is due at the next negedge.
   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         sb_entry_t e;
         logic [23:0] act;
         e   = sbq.pop_front();
         act = observe(e.sel);
         checks++;
         if (act === e.exp) passes++;
         else $display("FAIL %s: got 0x%06h expected 0x%06h", e.name, act, e.exp);
      end
   end

   task automatic expect_val(input string name, input int sel, input logic [23:0] exp);
      sb_entry_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rd_idx_1 = '0; rd_idx_2 = '0; wr_idx = '0; rsv_idx = '0;
      wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0; wr_data = '0;
      repeat (3) step();
      expect_val("reset_ready", S_RDY, 24'd0);
      expect_val("reset_rd1", S_RD1, 24'd0);
      expect_val("reset_busy2", S_BSY2, 24'd0);
      expect_val("reset_ready8", S_RDY8, 24'd0);

      // Release reset: 32 (resp. 8) not-ready cycles, then ready.
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         expect_val($sformatf("init_clear_ready_c%0d", i), S_RDY, 24'd0);
         expect_val($sformatf("init_clear_ready8_c%0d", i), S_RDY8, (i < 8) ? 24'd0 : 24'd1);
         step();
      end
      rd_idx_1 = 5'd0; rd_idx_2 = 5'd31;
      expect_val("ready_after_clear", S_RDY, 24'd1);
      expect_val("rd_idx0_zero", S_RD1, 24'd0);
      expect_val("rd_idx31_zero", S_RD2, 24'd0);
      expect_val("rd8_idx0_zero", S_RD81, 24'd0);

      // Short vs long writes.
      wr_en = 1'b1; wr_idx = 5'd5; wr_data = 24'hABCDEF; step();
      wr_idx = 5'd30; step();
      wr_en = 1'b0; rd_idx_1 = 5'd5; rd_idx_2 = 5'd30;
      expect_val("short_write_idx5", S_RD1, 24'h00CDEF);
      expect_val("long_write_idx30", S_RD2, 24'hABCDEF);
      expect_val("no_pending_idx5", S_BSY1, 24'd0);
      expect_val("rd8_short_idx5", S_RD81, 24'h00CDEF);
      expect_val("rd8_short_idx6", S_RD82, 24'h00CDEF);
      step();

      // Scoreboard reserve / release.
      rd_idx_1 = 5'd7; rsv_en = 1'b1; rsv_idx = 5'd7;
      expect_val("busy_before_rsv", S_BSY1, 24'd0);
      step();
      rsv_en = 1'b0;
      expect_val("busy_after_rsv", S_BSY1, 24'd1);
      expect_val("busy8_after_rsv", S_B81, 24'd1);
      wr_en = 1'b1; wr_idx = 5'd7; wr_data = 24'h001234;
`ifdef PRF_BYPASS_EN
      expect_val("busy_masked_on_write", S_BSY1, 24'd0);
`else
      expect_val("busy_held_on_write", S_BSY1, 24'd1);
`endif
      step();
      wr_en = 1'b0;
      expect_val("busy_released", S_BSY1, 24'd0);
      expect_val("rd_idx7_data", S_RD1, 24'h001234);
      rsv_en = 1'b1; rsv_idx = 5'd9; wr_en = 1'b1; wr_idx = 5'd9; wr_data = 24'h000077;
      rd_idx_2 = 5'd9;
      step();
      rsv_en = 1'b0; wr_en = 1'b0;
      expect_val("rsv_wins_busy", S_BSY2, 24'd1);
      expect_val("rsv_wins_data", S_RD2, 24'h000077);
      step();

      // Write-to-read forwarding on port 2.
      rd_idx_2 = 5'd3;
      expect_val("bypass_old_value", S_RD2, 24'd0);
      step();
      wr_en = 1'b1; wr_idx = 5'd3; wr_data = 24'h00BEEF;
`ifdef PRF_BYPASS_EN
      expect_val("bypass_same_cycle", S_RD2, 24'h00BEEF);
`else
      expect_val("no_bypass_same_cycle", S_RD2, 24'h000000);
`endif
      step();
      wr_en = 1'b0;
      expect_val("bypass_next_cycle", S_RD2, 24'h00BEEF);

      // Load idx 12, then bulk clear with late dropped write/reserve and an ignored clr_req.
      wr_en = 1'b1; wr_idx = 5'd12; wr_data = 24'h000055; step();
      wr_en = 1'b0; rd_idx_1 = 5'd12;
      expect_val("idx12_loaded", S_RD1, 24'h000055);
      clr_req = 1'b1; step();
      clr_req = 1'b0;
      for (int j = 0; j < 32; j++) begin
         expect_val($sformatf("bulk_clear_ready_c%0d", j), S_RDY, 24'd0);
         if (j == 1) expect_val("rd_gated_in_clear", S_RD1, 24'd0);
         if (j == 20) begin
            wr_en = 1'b1; wr_idx = 5'd12; wr_data = 24'h000099;
            rsv_en = 1'b1; rsv_idx = 5'd12;
         end
         if (j == 25) clr_req = 1'b1;
         step();
         wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
      end
      rd_idx_2 = 5'd9;
      expect_val("ready_after_bulk_clear", S_RDY, 24'd1);
      expect_val("idx12_cleared", S_RD1, 24'd0);
      expect_val("idx12_not_reserved", S_BSY1, 24'd0);
      expect_val("idx9_pending_cleared", S_BSY2, 24'd0);
      step();

      // Reset asserted ten cycles into a clear restarts the whole sequence.
      clr_req = 1'b1; step();
      clr_req = 1'b0;
      repeat (10) step();
      rst_n = 1'b0;
      step();
      expect_val("ready_low_in_reset", S_RDY, 24'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         expect_val($sformatf("restart_clear_ready_c%0d", i), S_RDY, 24'd0);
         if (i < 9) expect_val($sformatf("restart_clear_ready8_c%0d", i), S_RDY8, (i < 8) ? 24'd0 : 24'd1);
         step();
      end
      expect_val("ready_after_restart", S_RDY, 24'd1);
      rd_idx_1 = 5'd30; rd_idx_2 = 5'd7;
      expect_val("idx30_zero_after_restart", S_RD1, 24'd0);
      expect_val("rd8_idx7_zero_after_restart", S_RD82, 24'd0);
      step();
      wr_en = 1'b1; wr_idx = 5'd31; wr_data = 24'hFEDCBA; step();
      wr_en = 1'b0; rd_idx_1 = 5'd31; rd_idx_2 = 5'd31;
      expect_val("long_idx31", S_RD1, 24'hFEDCBA);
      expect_val("dual_read_same_idx", S_RD2, 24'hFEDCBA);
      expect_val("rd8_idx7_short", S_RD81, 24'h00DCBA);
      expect_val("rd8_busy_idle", S_B82, 24'd0);
      step();

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
      #1;
      if (sbq.size() > 0) begin
         checks++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor to the fixed 32-entry short/long register file. It stores NUM_REGS registers, where the top NUM_LONG indices are LONG_W wide and the rest are SHORT_W wide. The block adds four things: a sequenced bulk clear, a per-register pending scoreboard for multi-cycle producers, a ready flag, and optional write-to-read bypass. It sits between decode (read indices, reserve) and writeback (write port) in the CPU datapath.

## Interface
- SHORT_W, 16, width of short registers.
- LONG_W, 24, width of long registers and of all data ports; must be ≥ SHORT_W.
- NUM_REGS, 32, total register count; power of two, ≥ 2.
- NUM_LONG, 4, count of long registers.
  - They occupy indices NUM_REGS-NUM_LONG .. NUM_REGS-1.
  - Range 0..NUM_REGS.
- IDX_W, $clog2(NUM_REGS), index width (derived, not overridden).

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, **synchronous, active-low**.
- rd_idx_1, rd_idx_2  in  IDX_W  read indices.
- rd_data_1, rd_data_2  out  LONG_W  read data, combinational from index.
- busy_1, busy_2  out  1  addressed register has a pending producer.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_W  write index.
- wr_data  in  LONG_W  write data.
- rsv_en  in  1  reserve strobe: marks rsv_idx pending.
- rsv_idx  in  IDX_W  index to reserve.
- clr_req  in  1  request bulk clear (pulse).
- ready  out  1  register file usable.

## Operation
- Storage:
  - Short register: a write keeps wr_data[SHORT_W-1:0]; a read returns it zero-extended to LONG_W.
  - Long register: full LONG_W store and read.
- State machine has states CLEAR and IDLE.
  - Reset enters CLEAR with clr_ptr=0.
  - CLEAR writes zero to register clr_ptr each cycle and increments clr_ptr.
  - At clr_ptr=NUM_REGS-1, CLEAR writes zero and moves to IDLE the next cycle.
  - In IDLE, clr_req enters CLEAR with clr_ptr=0.
  - In CLEAR, clr_req is ignored.
- ready is 1 only in IDLE.
- While ready=0:
  - wr_en and rsv_en are dropped.
  - rd_data_n=0 and busy_n=0.
- Scoreboard: one pending bit per register, all cleared on reset and on entry to CLEAR.
  - rsv_en sets pending[rsv_idx].
  - A write to wr_idx clears pending[wr_idx].
  - If rsv_en and wr_en target the same index in the same cycle, reserve wins and the bit stays set (a new producer is issued).
- busy_n = pending[rd_idx_n]. With bypass enabled it is masked when a write to rd_idx_n occurs in the same cycle (see Configuration).
- Writing a register with no pending bit set is legal; its pending bit stays 0.
- Two reads of the same index return identical data.

## Timing
- Read latency is 0 cycles (combinational).
- A write commits at the rising edge where wr_en=1. Without bypass, it is visible on the read ports from the following cycle.
- Reserve: busy_n asserts the cycle after the rsv_en edge.
- Bulk clear:
  - ready=0 for exactly NUM_REGS cycles after the rst_n=0 → 1 edge, and for NUM_REGS cycles after an accepted clr_req.
  - ready=1 on cycle NUM_REGS+1.
- Reset values: all registers 0, all pending bits 0, ready=0, rd_data_n=0, busy_n=0.
- Reset asserted mid-clear: state returns to CLEAR, clr_ptr=0, and the full sequence restarts.

## Configuration
- Macro PRF_BYPASS_EN.
- Defined:
  - If wr_en=1, ready=1 and wr_idx=rd_idx_n, then rd_data_n returns the write data in the same cycle, truncated/zero-extended per the destination class.
  - busy_n=0 for that port in that cycle.
- Undefined:
  - Reads return stored contents only.
  - busy_n reflects pending bits as stored (clears the cycle after the write).

## Structure
- Package prf_pkg:
  - state enum (PRF_CLEAR, PRF_IDLE);
  - default width/depth localparams;
  - function that decides long vs short by index.
- Sub-module prf_scoreboard holds the pending vector and handles reserve/release/clear. It exports the pending bits indexed by both read ports.
- Top level holds the storage array, the clear FSM, the read muxes and the bypass.

## Test plan
- **Reset and clear:** release rst_n → ready=0 for 32 cycles, then 1; read indices 0 and 31 → 0x000000.
- **Short vs long write:** write 0xABCDEF to idx 5 and to idx 30, then read both → 0x00CDEF and 0xABCDEF.
- **Scoreboard:**
  - rsv idx 7 → next cycle busy_1=1 with rd_idx_1=7;
  - write 0x1234 to idx 7 → busy_1=0 the next cycle;
  - simultaneous rsv and write to idx 9 → busy stays 1.
- **Bypass:**
  - Write 0x00BEEF to idx 3 while rd_idx_2=3.
  - With PRF_BYPASS_EN: same cycle rd_data_2=0x00BEEF.
  - Without it: old value, then 0x00BEEF the next cycle.
- **Gated during clear:** clr_req after loading idx 12=0x55 → wr_en during CLEAR is dropped; after ready=1, idx 12 reads 0.
- **Reset mid-clear:** assert rst_n=0 at cycle 10 of CLEAR → after release ready=0 for a full 32 cycles again; non-default parameters (NUM_REGS=8, NUM_LONG=0) → 8-cycle clear and all reads 16-bit zero-extended.
